id_ex_stage_register: RTL and testbench
=======================================

# id_ex_stage_register

Decode-to-Execute pipeline register with integrated load-use hazard detection. Captures decoded operands, register specifiers and format flags from Decode, and presents them as the `_EX` signals consumed by the forwarding unit and the ALU. It inserts a one-cycle bubble and stalls Decode when a load in EX is followed by a dependent instruction, so the dependent operand can later be forwarded from `Loaded_Data_WB`. It also handles branch flush and downstream hold.

## Interface
- `XLEN`, default 32: operand and PC width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `Flush_EX` in 1: taken branch/jump resolved; kill the instruction entering EX.
- `Hold_EX` in 1: downstream stall; freeze the EX register.
- `Valid_ID` in 1: Decode holds a real instruction.
- `Operand1_ACU_ID`, `Operand1_DEU_ID`, `Operand2_DEU_ID`, `PC_ID` in XLEN: decoded operands and PC.
- `rs1_ID`, `rs2_ID`, `rd_ID` in 5: register specifiers.
- `Rs1_Valid_ID`, `Rs2_Valid_ID` in 1: source register specifiers are used.
- `Write_Enable_ID`, `Write_Back_Control_ID` in 1: rd written; write-back selects load data.
- `I_Type_Load_ID`, `S_Type_ID`, `J_Type_ID`, `I_Type_JAL_R_ID` in 1: format flags.
- Outputs, each registered with the matching `_EX` suffix and width: `Valid_EX`, the three operands, `PC_EX`, `rs1_EX`, `rs2_EX`, `rd_EX`, both valid bits, `Write_Enable_EX`, `Write_Back_Control_EX`, the four format flags.
- `Stall_ID` out 1: combinational; hold PC and the IF/ID register this cycle.

## Operation
- Load-use hazard `LU` is 1 when all of the following hold:
  - `Valid_EX & I_Type_Load_EX & Write_Enable_EX` and `rd_EX != 0`;
  - and either `Rs1_Valid_ID & (rs1_ID == rd_EX)` or `Rs2_Valid_ID & (rs2_ID == rd_EX)`;
  - and `Valid_ID`.
- `Stall_ID = Hold_EX | (LU & ~Flush_EX)`.
- Register update priority at each rising edge, highest first:
  1. `Flush_EX` → load bubble.
  2. `Hold_EX` → keep all `_EX` values.
  3. `LU` → load bubble.
  4. Otherwise → capture all `_ID` inputs; `Valid_EX <= Valid_ID`.
- Bubble: every `_EX` output, data and control, is loaded with 0.
- With `Valid_ID = 0` under normal capture, the control outputs `Write_Enable_EX`, `Rs1_Valid_EX`, `Rs2_Valid_EX` and the format flags are forced to 0. Data fields are still captured.
- Register x0 never triggers `LU`.
- A store whose data source (rs2) depends on a load still stalls; no special-case exemption.

## Timing
- Reset (asynchronous, any time, including mid-stall): all `_EX` outputs go to 0 immediately. `Stall_ID` then depends only on `Hold_EX`.
- Latency is 1 cycle from ID to EX under normal capture.
- A load-use stall is exactly 1 cycle:
  - The bubble enters EX, and `Valid_EX = 0` removes `LU` in the following cycle.
  - The dependent instruction enters EX when the load reaches WB.
- `Hold_EX` asserted N cycles:
  - EX is frozen N cycles and `Stall_ID` is high N cycles.
  - `LU` is evaluated again on release.
- `Flush_EX` together with `LU`: bubble, `Stall_ID = Hold_EX` (the dependent instruction is squashed upstream anyway).
- `Flush_EX` together with `Hold_EX`: bubble, `Stall_ID = 1`.

## Configuration
- `LOAD_USE_HAZARD_EN` defined: hazard detection as described above.
- `LOAD_USE_HAZARD_EN` undefined: `LU` is tied to 0 and `Stall_ID = Hold_EX`. Load-use ordering becomes the compiler's responsibility; all other behaviour is unchanged.

## Test plan
- Reset asserted mid-cycle with `Valid_EX = 1`, `rd_EX = 5` → all outputs 0 asynchronously, before the next edge.
- Normal flow: `rs1_ID = 3`, `Operand1_DEU_ID = 0x1234`, `Valid_ID = 1` → next cycle `rs1_EX = 3`, `Operand1_DEU_EX = 0x1234`, `Valid_EX = 1`, `Stall_ID = 0`.
- Load-use: EX holds a load with `rd_EX = 7`; ID has `rs2_ID = 7`, `Rs2_Valid_ID = 1` → `Stall_ID = 1` for one cycle, then a bubble in EX (`Valid_EX = 0`), then `rs2_EX = 7` one cycle later.
- Load-use cases that must not stall:
  - Load `rd_EX = 0` with `rs1_ID = 0` → `Stall_ID = 0`, no bubble.
  - Load `rd_EX = 7` with `Rs1_Valid_ID = 0`, `rs1_ID = 7` → `Stall_ID = 0`, no bubble.
- `Hold_EX = 1` for 3 cycles with changing ID inputs → `_EX` outputs unchanged and `Stall_ID = 1` for 3 cycles; captured data is released on cycle 4.
- `Flush_EX = 1` with `LU = 1` and `Hold_EX = 0` → bubble in EX, `Stall_ID = 0`.
- `Flush_EX = 1` with `LU = 1` and `Hold_EX = 1` → bubble in EX, `Stall_ID = 1`.
- `LOAD_USE_HAZARD_EN` undefined → the load-use case captures directly and `Stall_ID` stays 0.

Source files
------------

// File: rtl/id_ex_stage_register.sv
// id_ex_stage_register: ID/EX pipeline register with load-use bubble, flush and hold.
// Load-use detection is built only when LOAD_USE_HAZARD_EN is defined; otherwise Stall_ID = Hold_EX.
module id_ex_stage_register #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush_EX,
  input  logic            Hold_EX,
  input  logic            Valid_ID,
  input  logic [XLEN-1:0] Operand1_ACU_ID,
  input  logic [XLEN-1:0] Operand1_DEU_ID,
  input  logic [XLEN-1:0] Operand2_DEU_ID,
  input  logic [XLEN-1:0] PC_ID,
  input  logic [4:0]      rs1_ID,
  input  logic [4:0]      rs2_ID,
  input  logic [4:0]      rd_ID,
  input  logic            Rs1_Valid_ID,
  input  logic            Rs2_Valid_ID,
  input  logic            Write_Enable_ID,
  input  logic            Write_Back_Control_ID,
  input  logic            I_Type_Load_ID,
  input  logic            S_Type_ID,
  input  logic            J_Type_ID,
  input  logic            I_Type_JAL_R_ID,
  output logic            Valid_EX,
  output logic [XLEN-1:0] Operand1_ACU_EX,
  output logic [XLEN-1:0] Operand1_DEU_EX,
  output logic [XLEN-1:0] Operand2_DEU_EX,
  output logic [XLEN-1:0] PC_EX,
  output logic [4:0]      rs1_EX,
  output logic [4:0]      rs2_EX,
  output logic [4:0]      rd_EX,
  output logic            Rs1_Valid_EX,
  output logic            Rs2_Valid_EX,
  output logic            Write_Enable_EX,
  output logic            Write_Back_Control_EX,
  output logic            I_Type_Load_EX,
  output logic            S_Type_EX,
  output logic            J_Type_EX,
  output logic            I_Type_JAL_R_EX,
  output logic            Stall_ID
);
  localparam int W = 4 * XLEN + 24;
  logic [W-1:0] q, cap;
  logic lu;
`ifdef LOAD_USE_HAZARD_EN
  assign lu = Valid_ID & Valid_EX & I_Type_Load_EX & Write_Enable_EX & (rd_EX != 5'd0) &
              ((Rs1_Valid_ID & (rs1_ID == rd_EX)) | (Rs2_Valid_ID & (rs2_ID == rd_EX)));
`else
  assign lu = 1'b0;
`endif
  assign Stall_ID = Hold_EX | (lu & ~Flush_EX);
  // an invalid ID slot keeps its data but must not look like it reads, writes or has a format
  assign cap = {Valid_ID, Operand1_ACU_ID, Operand1_DEU_ID, Operand2_DEU_ID, PC_ID,
                rs1_ID, rs2_ID, rd_ID,
                Rs1_Valid_ID & Valid_ID, Rs2_Valid_ID & Valid_ID, Write_Enable_ID & Valid_ID,
                Write_Back_Control_ID,
                {I_Type_Load_ID, S_Type_ID, J_Type_ID, I_Type_JAL_R_ID} & {4{Valid_ID}}};
  assign {Valid_EX, Operand1_ACU_EX, Operand1_DEU_EX, Operand2_DEU_EX, PC_EX,
          rs1_EX, rs2_EX, rd_EX, Rs1_Valid_EX, Rs2_Valid_EX, Write_Enable_EX,
          Write_Back_Control_EX, I_Type_Load_EX, S_Type_EX, J_Type_EX, I_Type_JAL_R_EX} = q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (Flush_EX | (lu & ~Hold_EX)) q <= '0;
    else if (!Hold_EX) q <= cap;
endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb_id_ex_stage_register: directed table, corner sequences and randomized model check.
module tb_id_ex_stage_register;
`ifdef LOAD_USE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif
  typedef struct packed {
    logic valid;
    logic [31:0] op1a, op1d, op2d, pc;
    logic [4:0] rs1, rs2, rd;
    logic rs1v, rs2v, we, wbc, load, s, j, jalr;
  } fields_t;
  typedef struct {
    logic flush, hold, valid;
    logic [4:0] rs1, rs2, rd;
    logic rs1v, rs2v, we, load;
    logic [31:0] op;
    logic e_stall, e_v;
    logic [4:0] e_rs1, e_rd;
    logic [31:0] e_op;
    logic e_we;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, hold = 1'b0;
  fields_t id = '0, dut_ex, m = '0, nxt;
  logic stall;
  logic v_ex, rs1v_ex, rs2v_ex, we_ex, wbc_ex, ld_ex, s_ex, j_ex, jalr_ex;
  logic [31:0] op1a_ex, op1d_ex, op2d_ex, pc_ex;
  logic [4:0] rs1_ex, rs2_ex, rd_ex;
  int tests = 0, fails = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  id_ex_stage_register #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .Flush_EX(flush), .Hold_EX(hold), .Valid_ID(id.valid),
    .Operand1_ACU_ID(id.op1a), .Operand1_DEU_ID(id.op1d), .Operand2_DEU_ID(id.op2d), .PC_ID(id.pc),
    .rs1_ID(id.rs1), .rs2_ID(id.rs2), .rd_ID(id.rd), .Rs1_Valid_ID(id.rs1v), .Rs2_Valid_ID(id.rs2v),
    .Write_Enable_ID(id.we), .Write_Back_Control_ID(id.wbc), .I_Type_Load_ID(id.load),
    .S_Type_ID(id.s), .J_Type_ID(id.j), .I_Type_JAL_R_ID(id.jalr),
    .Valid_EX(v_ex), .Operand1_ACU_EX(op1a_ex), .Operand1_DEU_EX(op1d_ex), .Operand2_DEU_EX(op2d_ex),
    .PC_EX(pc_ex), .rs1_EX(rs1_ex), .rs2_EX(rs2_ex), .rd_EX(rd_ex), .Rs1_Valid_EX(rs1v_ex),
    .Rs2_Valid_EX(rs2v_ex), .Write_Enable_EX(we_ex), .Write_Back_Control_EX(wbc_ex),
    .I_Type_Load_EX(ld_ex), .S_Type_EX(s_ex), .J_Type_EX(j_ex), .I_Type_JAL_R_EX(jalr_ex),
    .Stall_ID(stall)
  );
  assign dut_ex = {v_ex, op1a_ex, op1d_ex, op2d_ex, pc_ex, rs1_ex, rs2_ex, rd_ex,
                   rs1v_ex, rs2v_ex, we_ex, wbc_ex, ld_ex, s_ex, j_ex, jalr_ex};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fields_t mkf(input logic valid, input logic [4:0] rs1, rs2, rd,
                                  input logic rs1v, rs2v, we, load, input logic [31:0] op);
    fields_t f = '0;
    f.valid = valid; f.rs1 = rs1; f.rs2 = rs2; f.rd = rd;
    f.rs1v = rs1v; f.rs2v = rs2v; f.we = we; f.load = load; f.op1d = op;
    return f;
  endfunction

  task automatic drive(input fields_t f, input logic fl, input logic hl);
    @(negedge clk);
    id = f; flush = fl; hold = hl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the EX slot as a record; a load in EX blocks an ID instruction that reads its rd.
  function automatic logic ref_lu(input fields_t ex, input fields_t d);
    if (!HAZ || !d.valid || !ex.valid || !ex.load || !ex.we || ex.rd == 5'd0) return 1'b0;
    return (d.rs1v && d.rs1 == ex.rd) || (d.rs2v && d.rs2 == ex.rd);
  endfunction

  function automatic fields_t ref_next(input fields_t ex, input fields_t d, input logic fl, hl);
    fields_t n = d;
    if (fl || (!hl && ref_lu(ex, d))) return '0;
    if (hl) return ex;
    if (!d.valid) begin
      n.rs1v = 1'b0; n.rs2v = 1'b0; n.we = 1'b0;
      n.load = 1'b0; n.s = 1'b0; n.j = 1'b0; n.jalr = 1'b0;
    end
    return n;
  endfunction

  initial begin
    fields_t f;
    logic exp_stall;
    tbl[0]  = '{1'b0,1'b0,1'b1,5'd3,5'd4,5'd5,1'b1,1'b1,1'b1,1'b0,32'h1234, 1'b0,1'b1,5'd3,5'd5,32'h1234,1'b1};
    tbl[1]  = '{1'b0,1'b0,1'b0,5'd9,5'd4,5'd2,1'b1,1'b1,1'b1,1'b0,32'h55,   1'b0,1'b0,5'd9,5'd2,32'h55,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,5'd1,5'd1,5'd1,1'b1,1'b1,1'b1,1'b0,32'h77,   1'b1,1'b0,5'd9,5'd2,32'h55,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b1,5'd6,5'd6,5'd6,1'b1,1'b1,1'b1,1'b1,32'h88,   1'b1,1'b0,5'd9,5'd2,32'h55,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,5'd2,5'd2,5'd2,1'b0,1'b0,1'b0,1'b0,32'h99,   1'b1,1'b0,5'd9,5'd2,32'h55,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,5'd1,5'd1,5'd1,1'b1,1'b1,1'b1,1'b0,32'h77,   1'b0,1'b1,5'd1,5'd1,32'h77,1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b1,5'd6,5'd6,5'd6,1'b1,1'b1,1'b1,1'b0,32'h66,   1'b0,1'b0,5'd0,5'd0,32'h0,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b1,5'd6,5'd6,5'd6,1'b1,1'b1,1'b1,1'b0,32'h66,   1'b1,1'b0,5'd0,5'd0,32'h0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,5'd0,5'd0,5'd7,1'b1,1'b1,1'b1,1'b1,32'hAA,   1'b0,1'b1,5'd0,5'd7,32'hAA,1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b1,5'd7,5'd3,5'd8,1'b0,1'b1,1'b1,1'b0,32'hBB,   1'b0,1'b1,5'd7,5'd8,32'hBB,1'b1};
    tbl[10] = '{1'b0,1'b0,1'b1,5'd2,5'd2,5'd0,1'b1,1'b1,1'b1,1'b1,32'hCC,   1'b0,1'b1,5'd2,5'd0,32'hCC,1'b1};
    tbl[11] = '{1'b0,1'b0,1'b1,5'd0,5'd0,5'd4,1'b1,1'b1,1'b1,1'b0,32'hDD,   1'b0,1'b1,5'd0,5'd4,32'hDD,1'b1};

    #12;
    chk("reset_state", 160'(dut_ex), 160'(0));
    @(negedge clk); reset = 1'b0;

    foreach (tbl[i]) begin
      drive(mkf(tbl[i].valid, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rs1v, tbl[i].rs2v,
                tbl[i].we, tbl[i].load, tbl[i].op), tbl[i].flush, tbl[i].hold);
      chk($sformatf("tbl%0d_stall", i), 160'(stall), 160'(tbl[i].e_stall));
      tick();
      chk($sformatf("tbl%0d_valid", i), 160'(v_ex), 160'(tbl[i].e_v));
      chk($sformatf("tbl%0d_rs1", i), 160'(rs1_ex), 160'(tbl[i].e_rs1));
      chk($sformatf("tbl%0d_rd", i), 160'(rd_ex), 160'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_op1", i), 160'(op1d_ex), 160'(tbl[i].e_op));
      chk($sformatf("tbl%0d_we", i), 160'(we_ex), 160'(tbl[i].e_we));
    end

    // load rd=7 followed by a store-like consumer reading rs2=7
    drive(mkf(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10), 1'b0, 1'b0);
    tick();
    drive(mkf(1'b1, 5'd7, 5'd7, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20), 1'b0, 1'b0);
    chk("lu_stall", 160'(stall), 160'(HAZ));
    tick();
    chk("lu_bubble_valid", 160'(v_ex), 160'(!HAZ));
    chk("lu_bubble_rs2", 160'(rs2_ex), HAZ ? 160'(0) : 160'(7));
    chk("lu_after_stall", 160'(stall), 160'(0));
    tick();
    chk("lu_dep_rs2", 160'(rs2_ex), 160'(7));
    chk("lu_dep_valid", 160'(v_ex), 160'(1));

    // flush wins over the hazard, with and without hold
    drive(mkf(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30), 1'b0, 1'b0);
    tick();
    drive(mkf(1'b1, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40), 1'b1, 1'b0);
    chk("flush_lu_stall", 160'(stall), 160'(0));
    tick();
    chk("flush_lu_bubble", 160'(dut_ex), 160'(0));
    drive(mkf(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h50), 1'b0, 1'b0);
    tick();
    drive(mkf(1'b1, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h60), 1'b1, 1'b1);
    chk("flush_hold_lu_stall", 160'(stall), 160'(1));
    tick();
    chk("flush_hold_bubble", 160'(dut_ex), 160'(0));

    // asynchronous reset in the middle of a cycle
    drive(mkf(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h70), 1'b0, 1'b0);
    tick();
    chk("pre_reset_rd", 160'(rd_ex), 160'(5));
    #2 reset = 1'b1; hold = 1'b1;
    #1;
    chk("async_reset_out", 160'(dut_ex), 160'(0));
    chk("reset_stall_hold", 160'(stall), 160'(1));
    hold = 1'b0;
    #1;
    chk("reset_stall_nohold", 160'(stall), 160'(0));
    @(negedge clk); reset = 1'b0;
    m = '0;

    for (int n = 0; n < 400; n++) begin
      f = '0;
      f.valid = $urandom_range(0, 4) != 0;
      f.op1a = $urandom; f.op1d = $urandom; f.op2d = $urandom; f.pc = $urandom;
      f.rs1 = 5'($urandom_range(0, 3)); f.rs2 = 5'($urandom_range(0, 3)); f.rd = 5'($urandom_range(0, 3));
      f.rs1v = 1'($urandom); f.rs2v = 1'($urandom); f.we = $urandom_range(0, 3) != 0;
      f.wbc = 1'($urandom); f.load = 1'($urandom); f.s = 1'($urandom);
      f.j = 1'($urandom); f.jalr = 1'($urandom);
      drive(f, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      exp_stall = hold || (ref_lu(m, id) && !flush);
      nxt = ref_next(m, id, flush, hold);
      chk($sformatf("rnd%0d_stall", n), 160'(stall), 160'(exp_stall));
      tick();
      chk($sformatf("rnd%0d_ex", n), 160'(dut_ex), 160'(nxt));
      m = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
